// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_if
//  Description : Operand/result handshake bundle for nibble_serial_adder.
//                The master side produces operands and consumes results;
//                the slave side is the adder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder
//  Description : 4-bit ripple-carry adder built from full-adder cells.
//  Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder (
  input  wire logic [3:0] a_i,
  input  wire logic [3:0] b_i,
  input  wire logic       c_i,
  output logic      [3:0] s_o,
  output logic            c_o
);
  logic [4:0] w_carry;

  assign w_carry[0] = c_i;

  for (genvar g = 0; g < 4; g++) begin : g_bit
    assign s_o[g]         = a_i[g] ^ b_i[g] ^ w_carry[g];
    assign w_carry[g + 1] = (a_i[g] & b_i[g]) | (w_carry[g] & (a_i[g] ^ b_i[g]));
  end

  assign c_o = w_carry[4];
endmodule

// ============================================================================
//  Module      : nibble_serial_adder
//  Description : WIDTH-bit adder that processes one nibble per clock through
//                a single 4-bit ripple-carry adder, LS nibble first, with the
//                carry registered between nibbles. Valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  nibble_serial_adder_if.slave    bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q;

  logic [3:0]         w_nib_a, w_nib_b, w_nib_sum;
  logic               w_nib_cout;
  logic               w_last;
  logic               w_in_ready, w_out_valid, w_busy;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    w_nib_a = 4'd0;
    w_nib_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_nib_a = a_q[4*i +: 4];
        w_nib_b = b_q[4*i +: 4];
      end
    end
  end

  ripple_carry_adder u_rca (
    .a_i (w_nib_a),
    .b_i (w_nib_b),
    .c_i (carry_q),
    .s_o (w_nib_sum),
    .c_o (w_nib_cout)
  );

  assign w_last = (idx_q == IDX_W'(NIBBLES - 1));

  // Merge the freshly computed nibble into the result; other nibbles hold.
  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sum_d[4*i +: 4] = w_nib_sum;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; in_ready is masked by reset so the
  // producer never sees a stale acceptance while the block is held in reset.
  always_comb begin
    state_d     = state_q;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (state_q)
      IDLE: begin
        w_in_ready = rst_n;
        if (bus.in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture in IDLE, one nibble per cycle in RUN; DONE holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= w_nib_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (w_last) begin
            cout_q <= w_nib_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Directed self-checking bench for nibble_serial_adder at
//                WIDTH=16, plus a WIDTH=4 instance for the single-nibble case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4  ();

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=16 transaction: accept, measure latency, check result, release.
  task automatic do_op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
    int cnt;
    check({tag, " in_ready"}, 32'(bus16.in_ready), 32'd1);
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = cin;
    bus16.in_valid = 1'b1;
    bus16.out_ready = 1'b0;
    tick();
    bus16.in_valid = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus16.out_valid && cnt < 20);
    check({tag, " latency"}, 32'(cnt), 32'd4);
    check({tag, " sum"},     32'(bus16.sum), 32'(exp_sum));
    check({tag, " cout"},    32'(bus16.cout), 32'(exp_cout));
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(bus16.out_valid), 32'd0);
    check({tag, " idle busy"},      32'(bus16.busy), 32'd0);
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst out_valid", 32'(bus16.out_valid), 32'd0);
    check("rst busy",      32'(bus16.busy), 32'd0);
    check("rst sum",       32'(bus16.sum), 32'd0);
    check("rst cout",      32'(bus16.cout), 32'd0);
    check("rst in_ready",  32'(bus16.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", 32'(bus16.in_ready), 32'd1);

    // Basic adds and full-length carry propagation.
    do_op16("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_op16("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op16("t3a", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    do_op16("t3b", 16'h0C0A, 16'h0A0C, 1'b0, 16'h1616, 1'b0);

    // Backpressure in DONE: result must hold for 5 stalled cycles.
    bus16.a = 16'hA5A5; bus16.b = 16'h1111; bus16.cin = 1'b1; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (!bus16.out_valid && cnt < 20);
    check("t4 latency", 32'(cnt), 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4 hold valid", 32'(bus16.out_valid), 32'd1);
      check("t4 hold sum",   32'(bus16.sum), 32'h0000B6B7);
      check("t4 hold cout",  32'(bus16.cout), 32'd0);
    end
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check("t4 release valid", 32'(bus16.out_valid), 32'd0);
    check("t4 release ready", 32'(bus16.in_ready), 32'd1);

    // in_valid held high with different operands while busy must be ignored.
    bus16.a = 16'h0100; bus16.b = 16'h0200; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    tick();
    bus16.a = 16'h7777; bus16.b = 16'h1111; bus16.cin = 1'b1;
    cnt = 0;
    do begin
      check("t5 in_ready busy", 32'(bus16.in_ready), 32'd0);
      tick();
      cnt++;
    end while (!bus16.out_valid && cnt < 20);
    check("t5 latency", 32'(cnt), 32'd4);
    check("t5 in_ready done", 32'(bus16.in_ready), 32'd0);
    check("t5 sum first", 32'(bus16.sum), 32'h00000300);
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check("t5 idle ready", 32'(bus16.in_ready), 32'd1);
    tick();
    bus16.in_valid = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (!bus16.out_valid && cnt < 20);
    check("t5 latency2", 32'(cnt), 32'd4);
    check("t5 sum second",  32'(bus16.sum), 32'h00008889);
    check("t5 cout second", 32'(bus16.cout), 32'd0);
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;

    // Reset in the middle of RUN aborts the operation.
    bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.cin = 1'b1; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t6 out_valid", 32'(bus16.out_valid), 32'd0);
    check("t6 busy",      32'(bus16.busy), 32'd0);
    check("t6 sum",       32'(bus16.sum), 32'd0);
    check("t6 cout",      32'(bus16.cout), 32'd0);
    check("t6 in_ready",  32'(bus16.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6 no result", 32'(bus16.out_valid), 32'd0);
    end
    do_op16("t6 fresh", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);

    // WIDTH=4: single RUN cycle.
    check("w4 in_ready", 32'(bus4.in_ready), 32'd1);
    bus4.a = 4'hF; bus4.b = 4'h1; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (!bus4.out_valid && cnt < 20);
    check("w4a latency", 32'(cnt), 32'd1);
    check("w4a sum",     32'(bus4.sum), 32'h1);
    check("w4a cout",    32'(bus4.cout), 32'd1);
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check("w4a drop", 32'(bus4.out_valid), 32'd0);
    bus4.a = 4'h3; bus4.b = 4'h4; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (!bus4.out_valid && cnt < 20);
    check("w4b latency", 32'(cnt), 32'd1);
    check("w4b sum",     32'(bus4.sum), 32'h7);
    check("w4b cout",    32'(bus4.cout), 32'd0);
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
